// File: rtl/pc_gen_pkg.sv
// Core-wide definitions shared by the program-counter generator and its users.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_RET,
        SRC_JR,
        SRC_J,
        SRC_BR,
        SRC_SEQ
    } next_src_e;

    function automatic bit pc_step_legal(input int unsigned step);
        return (step == 1) || (step == 4);
    endfunction

    // Number of implicit low zero bits in jump targets and branch offsets.
    function automatic int unsigned js_shift(input int unsigned step);
        return (step == 4) ? 2 : 0;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control/flag bundle between decoder/ALU (master) and the PC generator (slave).
interface pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_offset;
    logic              jump;
    logic [25:0]       jump_index;
    logic              jump_reg;
    logic [ADDR_W-1:0] jump_reg_addr;
    logic              call;
    logic              ret;
    logic              exc;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] post_pc;
    logic              pc_valid;
    logic              exc_taken;
    logic              ras_overflow;
    logic              ras_underflow;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_index,
               jump_reg, jump_reg_addr, call, ret, exc,
        input  pc, post_pc, pc_valid, exc_taken, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_index,
               jump_reg, jump_reg_addr, call, ret, exc,
        output pc, post_pc, pc_valid, exc_taken, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a push on a full stack overwrites the oldest entry.
module pc_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              stall,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_ras: RAS_DEPTH must be a power of 2 and at least 2");
    end

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]     r_wp;
    logic [CW-1:0]     r_cnt;
    logic              r_overflow;
    logic              r_underflow;

    logic [PW-1:0] w_top_idx;
    logic [PW-1:0] w_wr_idx;
    logic          w_push_only;
    logic          w_pop_only;
    logic          w_swap;
    logic          w_wr_en;

    assign w_top_idx   = r_wp - PW'(1);
    assign top         = r_mem[w_top_idx];
    assign empty       = (r_cnt == '0);
    assign full        = (r_cnt == CW'(RAS_DEPTH));
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    assign w_push_only = !stall && push && !pop;
    assign w_pop_only  = !stall && pop && !push;
    assign w_swap      = !stall && push && pop;
    assign w_wr_en     = w_push_only || w_swap;
    // A call+ret pair replaces the top in place unless there is no top to replace.
    assign w_wr_idx    = (w_swap && !empty) ? w_top_idx : r_wp;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp        <= '0;
            r_cnt       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_only || (w_swap && empty)) begin
                r_wp <= r_wp + PW'(1);
                if (full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            if ((w_swap || w_pop_only) && empty) begin
                r_underflow <= 1'b1;
            end
            if (w_pop_only && !empty) begin
                r_wp  <= w_top_idx;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end
endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: clocked PC with stall, prioritised redirect and a return stack.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                PC_STEP   = 1,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h20),
    parameter int                RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     rst_n,
    pc_gen_if.slave bus
);
    localparam int unsigned       JS      = js_shift(PC_STEP);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] HI_MASK = ~((ADDR_W'(1) << (26 + JS)) - ADDR_W'(1));

    if (!pc_step_legal(PC_STEP) || ADDR_W < 28) begin : g_bad_param
        $error("pc_gen: PC_STEP must be 1 or 4 and ADDR_W at least 28");
    end

    logic [ADDR_W-1:0] r_pc;
    logic              r_pc_valid;
    logic              r_exc_taken;

    next_src_e         w_src;
    logic [ADDR_W-1:0] w_post_pc;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_next;
    logic              w_ret_empty;
    logic              w_misalign;
    logic              w_redirect_exc;
    logic              w_ras_en;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;
    logic              w_ras_full;

    assign w_post_pc  = r_pc + STEP;
    assign w_jump_tgt = (w_post_pc & HI_MASK) | (ADDR_W'(bus.jump_index) << JS);
    assign w_br_tgt   = w_post_pc + (bus.branch_offset << JS);

    always_comb begin
        w_src = SRC_SEQ;
        if (bus.exc)               w_src = SRC_EXC;
        else if (bus.ret)          w_src = SRC_RET;
        else if (bus.jump_reg)     w_src = SRC_JR;
        else if (bus.jump)         w_src = SRC_J;
        else if (bus.branch_taken) w_src = SRC_BR;
    end

    always_comb begin
        w_target    = w_post_pc;
        w_ret_empty = 1'b0;
        case (w_src)
            SRC_EXC: w_target = EXC_VEC;
            SRC_RET: begin
                w_target    = w_ras_empty ? EXC_VEC : w_ras_top;
                w_ret_empty = w_ras_empty;
            end
            SRC_JR:  w_target = bus.jump_reg_addr;
            SRC_J:   w_target = w_jump_tgt;
            SRC_BR:  w_target = w_br_tgt;
            default: w_target = w_post_pc;
        endcase
    end

    assign w_misalign     = (PC_STEP == 4) && (w_target[1:0] != 2'b00);
    assign w_next         = w_misalign ? EXC_VEC : w_target;
    assign w_redirect_exc = (w_src == SRC_EXC) || w_ret_empty || w_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_pc_valid  <= 1'b0;
            r_exc_taken <= 1'b0;
        end else if (!r_pc_valid) begin
            r_pc_valid  <= 1'b1;
            r_exc_taken <= 1'b0;
        end else if (bus.exc) begin
            // Exceptions are honoured even while the pipeline is stalled.
            r_pc        <= EXC_VEC;
            r_exc_taken <= 1'b1;
        end else if (bus.stall) begin
            r_exc_taken <= 1'b0;
        end else begin
            r_pc        <= w_next;
            r_exc_taken <= w_redirect_exc;
        end
    end

    assign w_ras_en = r_pc_valid && !bus.exc;

    pc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.call && w_ras_en),
        .pop       (bus.ret && w_ras_en),
        .stall     (bus.stall),
        .push_data (w_post_pc),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full),
        .overflow  (bus.ras_overflow),
        .underflow (bus.ras_underflow)
    );

    assign bus.pc        = r_pc;
    assign bus.post_pc   = w_post_pc;
    assign bus.pc_valid  = r_pc_valid;
    assign bus.exc_taken = r_exc_taken;
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: word-mode and byte-mode instances sharing clock and reset.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(32)) wi ();
    pc_gen_if #(.ADDR_W(32)) bi ();

    pc_gen #(.ADDR_W(32), .PC_STEP(1), .RESET_PC(32'h0), .EXC_VEC(32'h20), .RAS_DEPTH(4))
        dut_w (.clk(clk), .rst_n(rst_n), .bus(wi));
    pc_gen #(.ADDR_W(32), .PC_STEP(4), .RESET_PC(32'h100), .EXC_VEC(32'h20), .RAS_DEPTH(4))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bi));

    typedef struct {
        logic        stall, br, j, jr, call, ret, exc;
        logic [31:0] off;
        logic [25:0] idx;
        logic [31:0] jra;
    } ctl_t;

    typedef struct {
        logic [31:0] pc;
        logic        exc;
        logic        valid;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic ctl_t nop();
        ctl_t c;
        c = '{default: '0};
        return c;
    endfunction

    task automatic drive_w(input ctl_t c);
        wi.stall = c.stall; wi.branch_taken = c.br; wi.branch_offset = c.off;
        wi.jump = c.j; wi.jump_index = c.idx; wi.jump_reg = c.jr;
        wi.jump_reg_addr = c.jra; wi.call = c.call; wi.ret = c.ret; wi.exc = c.exc;
    endtask

    task automatic drive_b(input ctl_t c);
        bi.stall = c.stall; bi.branch_taken = c.br; bi.branch_offset = c.off;
        bi.jump = c.j; bi.jump_index = c.idx; bi.jump_reg = c.jr;
        bi.jump_reg_addr = c.jra; bi.call = c.call; bi.ret = c.ret; bi.exc = c.exc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        drive_w(nop());
        drive_b(nop());
        #12;
        total++;
        if (wi.pc !== 32'h0 || wi.pc_valid !== 1'b0 || wi.exc_taken !== 1'b0) begin
            bad++;
            $display("FAIL reset_state pc=%h valid=%b exc=%b want 0/0/0", wi.pc, wi.pc_valid, wi.exc_taken);
        end
        total++;
        if (wi.ras_overflow !== 1'b0 || wi.ras_underflow !== 1'b0 || wi.post_pc !== 32'h1) begin
            bad++;
            $display("FAIL reset_flags ovf=%b unf=%b post_pc=%h want 0/0/1", wi.ras_overflow, wi.ras_underflow, wi.post_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back('{32'(i), 1'b0, 1'b1});
            tick();
            e = sb_q.pop_front();
            total++;
            if (wi.pc !== e.pc || wi.exc_taken !== e.exc || wi.pc_valid !== e.valid) begin
                bad++;
                $display("FAIL reset_release[%0d] pc=%h exc=%b valid=%b want pc=%h exc=%b valid=%b",
                         i, wi.pc, wi.exc_taken, wi.pc_valid, e.pc, e.exc, e.valid);
            end
        end
    endtask

    task automatic test_branch_jump();
        ctl_t c;
        exp_t e;
        logic [31:0] want;
        for (int i = 0; i < 10; i++) begin
            c = nop();
            want = 32'(4 + i);
            if (i == 7) begin c.br = 1; c.off = 32'hFFFF_FFFD; want = 32'd8; end
            if (i == 8) begin c.j = 1; c.idx = 26'h40; c.br = 1; c.off = 32'd100; want = 32'h40; end
            if (i == 9) begin
                c.jr = 1; c.jra = 32'd5; c.j = 1; c.idx = 26'h3; c.br = 1; c.off = 32'd7; want = 32'd5;
            end
            drive_w(c);
            sb_q.push_back('{want, 1'b0, 1'b1});
            tick();
            e = sb_q.pop_front();
            total++;
            if (wi.pc !== e.pc || wi.exc_taken !== e.exc) begin
                bad++;
                $display("FAIL branch_jump[%0d] pc=%h exc=%b want pc=%h exc=%b", i, wi.pc, wi.exc_taken, e.pc, e.exc);
            end
        end
    endtask

    task automatic test_ras();
        ctl_t c;
        exp_t e;
        logic [31:0] ret_pc [5] = '{32'd10, 32'd9, 32'd8, 32'd7, 32'h20};
        for (int i = 0; i < 5; i++) begin
            c = nop(); c.call = 1;
            drive_w(c);
            sb_q.push_back('{32'(6 + i), 1'b0, 1'b1});
            tick();
            e = sb_q.pop_front();
            total++;
            if (wi.pc !== e.pc || wi.ras_overflow !== (i == 4)) begin
                bad++;
                $display("FAIL ras_call[%0d] pc=%h ovf=%b want pc=%h ovf=%b", i, wi.pc, wi.ras_overflow, e.pc, i == 4);
            end
        end
        for (int i = 0; i < 5; i++) begin
            c = nop(); c.ret = 1;
            drive_w(c);
            sb_q.push_back('{ret_pc[i], i == 4, 1'b1});
            tick();
            e = sb_q.pop_front();
            total++;
            if (wi.pc !== e.pc || wi.exc_taken !== e.exc || wi.ras_underflow !== (i == 4)) begin
                bad++;
                $display("FAIL ras_ret[%0d] pc=%h exc=%b unf=%b want pc=%h exc=%b unf=%b",
                         i, wi.pc, wi.exc_taken, wi.ras_underflow, e.pc, e.exc, i == 4);
            end
        end
        drive_w(nop());
        sb_q.push_back('{32'h21, 1'b0, 1'b1});
        tick();
        e = sb_q.pop_front();
        total++;
        if (wi.pc !== e.pc || wi.exc_taken !== e.exc) begin
            bad++;
            $display("FAIL ras_after pc=%h exc=%b want pc=%h exc=%b", wi.pc, wi.exc_taken, e.pc, e.exc);
        end
    endtask

    task automatic test_stall();
        ctl_t c;
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            c = nop();
            case (i)
                0:       begin c.call = 1; sb_q.push_back('{32'h22, 1'b0, 1'b1}); end
                1, 2, 3: begin c.stall = 1; c.call = 1; c.br = 1; c.off = 32'd5;
                               sb_q.push_back('{32'h22, 1'b0, 1'b1}); end
                4:       begin c.ret = 1; sb_q.push_back('{32'h22, 1'b0, 1'b1}); end
                5:       begin c.ret = 1; sb_q.push_back('{32'h20, 1'b1, 1'b1}); end
                6:       sb_q.push_back('{32'h21, 1'b0, 1'b1});
                7:       begin c.stall = 1; c.exc = 1; sb_q.push_back('{32'h20, 1'b1, 1'b1}); end
                default: begin c.stall = 1; sb_q.push_back('{32'h20, 1'b0, 1'b1}); end
            endcase
            drive_w(c);
            tick();
            e = sb_q.pop_front();
            total++;
            if (wi.pc !== e.pc || wi.exc_taken !== e.exc) begin
                bad++;
                $display("FAIL stall[%0d] pc=%h exc=%b want pc=%h exc=%b", i, wi.pc, wi.exc_taken, e.pc, e.exc);
            end
        end
        drive_w(nop());
    endtask

    task automatic test_byte_mode();
        ctl_t c;
        exp_t e;
        rst_n = 1'b0;
        drive_b(nop());
        drive_w(nop());
        #3;
        total++;
        if (bi.pc !== 32'h100 || bi.pc_valid !== 1'b0) begin
            bad++;
            $display("FAIL byte_reset pc=%h valid=%b want 100/0", bi.pc, bi.pc_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c = nop();
            case (i)
                0:       sb_q.push_back('{32'h100, 1'b0, 1'b1});
                1:       begin c.br = 1; c.off = 32'd2; sb_q.push_back('{32'h10C, 1'b0, 1'b1}); end
                2:       begin c.jr = 1; c.jra = 32'h100; sb_q.push_back('{32'h100, 1'b0, 1'b1}); end
                3:       begin c.jr = 1; c.jra = 32'h202; sb_q.push_back('{32'h20, 1'b1, 1'b1}); end
                default: begin c.j = 1; c.idx = 26'h10; sb_q.push_back('{32'h40, 1'b0, 1'b1}); end
            endcase
            drive_b(c);
            tick();
            e = sb_q.pop_front();
            total++;
            if (bi.pc !== e.pc || bi.exc_taken !== e.exc || bi.pc_valid !== e.valid) begin
                bad++;
                $display("FAIL byte_mode[%0d] pc=%h exc=%b valid=%b want pc=%h exc=%b valid=%b",
                         i, bi.pc, bi.exc_taken, bi.pc_valid, e.pc, e.exc, e.valid);
            end
        end
        drive_b(nop());
        total++;
        if (bi.post_pc !== 32'h44 || bi.ras_overflow !== 1'b0 || bi.ras_underflow !== 1'b0) begin
            bad++;
            $display("FAIL byte_post_pc post_pc=%h ovf=%b unf=%b want 44/0/0", bi.post_pc, bi.ras_overflow, bi.ras_underflow);
        end
    endtask

    task automatic test_mid_reset();
        ctl_t c;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            c = nop(); c.call = 1;
            drive_w(c);
            sb_q.push_back('{32'(5 + i), 1'b0, 1'b1});
            tick();
            e = sb_q.pop_front();
            total++;
            if (wi.pc !== e.pc) begin
                bad++;
                $display("FAIL mid_reset_call[%0d] pc=%h want pc=%h", i, wi.pc, e.pc);
            end
        end
        drive_w(nop());
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (wi.pc !== 32'h0 || wi.pc_valid !== 1'b0 || wi.ras_underflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_async pc=%h valid=%b unf=%b want 0/0/0", wi.pc, wi.pc_valid, wi.ras_underflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            c = nop();
            c.ret = (i == 1);
            drive_w(c);
            sb_q.push_back((i == 0) ? '{32'h0, 1'b0, 1'b1} : '{32'h20, 1'b1, 1'b1});
            tick();
            e = sb_q.pop_front();
            total++;
            if (wi.pc !== e.pc || wi.exc_taken !== e.exc || wi.pc_valid !== e.valid) begin
                bad++;
                $display("FAIL mid_reset_after[%0d] pc=%h exc=%b valid=%b want pc=%h exc=%b valid=%b",
                         i, wi.pc, wi.exc_taken, wi.pc_valid, e.pc, e.exc, e.valid);
            end
        end
        drive_w(nop());
        total++;
        if (wi.ras_underflow !== 1'b1 || wi.ras_overflow !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_flags unf=%b ovf=%b want 1/0", wi.ras_underflow, wi.ras_overflow);
        end
    endtask

    initial begin
        test_reset();
        test_branch_jump();
        test_ras();
        test_stall();
        test_byte_mode();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the MIPS core, replacing the single-cycle PC/adder/mux block. Holds a properly clocked PC register with stall, prioritised redirect (exception, return, register jump, J-type jump, branch) and a hardware return-address stack (RAS) for call/return pairs. Sits between the decoder/ALU flags and the instruction-memory address port.

## Interface
- ADDR_W, 32: PC width in bits (≥ 28).
- PC_STEP, 1: increment per instruction; 1 is word-addressed, 4 is byte-addressed. No other values are legal.
- RESET_PC, 0: PC value in and after reset.
- EXC_VEC, 'h20: exception-handler address.
- RAS_DEPTH, 4: return-stack entries, a power of 2 and ≥ 2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and RAS.
- branch_taken  in  1  resolved conditional branch, already ANDed with its ALU flag.
- branch_offset  in  ADDR_W  sign-extended offset, in PC_STEP units.
- jump  in  1  J-type jump.
- jump_index  in  26  J-type target field.
- jump_reg  in  1  register jump.
- jump_reg_addr  in  ADDR_W  register jump target.
- call  in  1  push post_pc onto the RAS (jal/jalr).
- ret  in  1  return: pop the RAS and redirect to the popped value.
- exc  in  1  external exception request.
- pc  out  ADDR_W  current fetch address.
- post_pc  out  ADDR_W  pc + PC_STEP (combinational).
- pc_valid  out  1  pc is a real fetch address.
- exc_taken  out  1  one-cycle pulse: an exception redirect occurred this edge.
- ras_overflow  out  1  sticky: a push happened while the RAS was full.
- ras_underflow  out  1  sticky: a pop happened while the RAS was empty.

## Operation
- Control inputs describe the instruction at the current pc.
- Next-PC selection, highest priority first:
  1. exc: EXC_VEC.
  2. ret: the RAS top entry.
  3. jump_reg: jump_reg_addr.
  4. jump: {post_pc[ADDR_W-1:26+JS], jump_index, JS zero bits}, where JS = 0 for PC_STEP=1 and 2 for PC_STEP=4.
  5. branch_taken: post_pc + branch_offset*PC_STEP, modulo 2^ADDR_W.
  6. Otherwise: post_pc.
- Misalignment (PC_STEP=4 only): a selected target with bits [1:0] ≠ 0 becomes EXC_VEC and asserts exc_taken.
- ret on an empty RAS: target is EXC_VEC, exc_taken asserts, ras_underflow sets, and the pointer and count are unchanged.
- call alone: writes post_pc at the write pointer and advances it.
  - Count saturates at RAS_DEPTH.
  - On a full RAS, the oldest entry is overwritten (circular) and ras_overflow sets.
- call and ret in the same cycle: the redirect uses the old top, then post_pc replaces the top. Count is unchanged; on an empty RAS this becomes a plain push plus an underflow.
- stall=1: pc, RAS and count hold, and call/ret are ignored.
  - exc overrides stall: pc still loads EXC_VEC.
  - exc does not modify the RAS.
- All pc arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset (asynchronous, immediate):
  - pc = RESET_PC, pc_valid = 0, exc_taken = 0.
  - RAS count = 0, pointer = 0, both sticky flags = 0.
  - RAS entry contents are don't-care.
- First rising edge after rst_n deasserts: pc_valid becomes 1 and pc stays RESET_PC, so the first fetch is RESET_PC. While pc_valid = 0, all control inputs are ignored.
- Every later edge with pc_valid = 1: pc ← selected next PC. Redirect latency is one edge; there is no delay slot.
- exc_taken is registered and is high for exactly the cycle after the redirecting edge.
- RAS write/pop commits on the same edge as the pc update.
- post_pc and the next-PC mux are combinational from pc and the inputs.

## Structure
- Shared package (core-wide) holds:
  - the PC_STEP legality check;
  - the JS-shift function;
  - the next-PC source enum (SRC_EXC, SRC_RET, SRC_JR, SRC_J, SRC_BR, SRC_SEQ).
- One sub-module, pc_ras: a circular LIFO parametrised by ADDR_W and RAS_DEPTH.
  - Inputs: push, pop, push_data, stall.
  - Outputs: top, empty, full, overflow, underflow.
- pc_gen contains the PC register, the adder/mux and the valid/exception flops.

## Test plan
- Reset release with RESET_PC=0, PC_STEP=1, no controls: pc reads 0, 0, 1, 2, 3 on successive edges; pc_valid rises after the first edge.
- Word mode, pc=10: branch_taken with offset −3 gives pc=8. At pc=8, jump with jump_index=0x40 gives pc=0x40; asserting jump and branch_taken together takes the jump.
- RAS_DEPTH=4:
  - call at pcs 5, 6, 7, 8, 9 sets ras_overflow on the fifth call.
  - Five rets then go to 10, 9, 8, 7 and then EXC_VEC, with ras_underflow and exc_taken asserted.
- stall held 3 cycles with call and branch_taken asserted: pc and count are unchanged. exc during stall still gives pc=EXC_VEC and a one-cycle exc_taken.
- PC_STEP=4, pc=0x100: jump_reg to 0x202 redirects to EXC_VEC with exc_taken; branch offset 2 from 0x100 gives 0x10C.
- rst_n asserted mid-sequence with 2 RAS entries: pc=RESET_PC immediately, and after release a ret underflows.
